// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to count 0..width inclusive.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, built from two half-subtractor stages.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  logic d1;
  logic b1;
  logic b2;

  // first half stage: x - y
  assign d1 = x ^ y;
  assign b1 = ~x & y;

  // second half stage: (x - y) - bi
  assign d  = d1 ^ bi;
  assign b2 = ~d1 & bi;

  assign bo = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first: diff = a - b - bin, with borrow/overflow/zero flags.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             borrow_r;
  logic             b_msb_in;
  logic [CW-1:0]    cnt;
  logic             load_c;
  logic             shift_c;
  logic             last_c;
  logic             d_c;
  logic             bo_c;

  full_subtractor u_fs (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (borrow_r),
    .d  (d_c),
    .bo (bo_c)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state and datapath controls
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    shift_c   = 1'b0;
    last_c    = (cnt == CW'(WIDTH - 1));
    case (state)
      IDLE: begin
        if (start) begin
          load_c    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_c = 1'b1;
        if (last_c) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          load_c    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // shift datapath and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      r_sr     <= '0;
      borrow_r <= 1'b0;
      b_msb_in <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else begin
      busy <= (state_nxt == SHIFT);
      done <= (state == DONE);
      // results use the final borrow before a back-to-back load overwrites it
      if (state == DONE) begin
        diff <= r_sr;
        bout <= borrow_r;
        ovf  <= b_msb_in ^ borrow_r;
        zero <= (r_sr == '0);
      end
      if (load_c) begin
        a_sr     <= a;
        b_sr     <= b;
        borrow_r <= bin;
        cnt      <= '0;
      end else if (shift_c) begin
        a_sr     <= {1'b0, a_sr[WIDTH-1:1]};
        b_sr     <= {1'b0, b_sr[WIDTH-1:1]};
        r_sr     <= {d_c, r_sr[WIDTH-1:1]};
        borrow_r <= bo_c;
        cnt      <= cnt + CW'(1);
        if (last_c) b_msb_in <= borrow_r;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor at WIDTH=8 and WIDTH=13.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        s8, bin8, s13, bin13;
  logic [7:0]  a8, b8;
  logic [12:0] a13, b13;
  logic        busy8, done8, bout8, ovf8, zero8;
  logic [7:0]  diff8;
  logic        busy13, done13, bout13, ovf13, zero13;
  logic [12:0] diff13;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8), .zero(zero8)
  );

  serial_subtractor #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst(rst), .start(s13), .a(a13), .b(b13), .bin(bin13),
    .busy(busy13), .done(done13), .diff(diff13), .bout(bout13), .ovf(ovf13), .zero(zero13)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic cur_done(input int w);
    return (w == 8) ? done8 : done13;
  endfunction

  // reference: integer arithmetic, independent of the serial structure
  task automatic model(input int w, input logic [15:0] av, input logic [15:0] bv, input logic bi,
                       output logic [15:0] d, output logic bo, output logic ov, output logic z);
    int mask, ua, ub, r, sa, sb, sr;
    mask = (1 << w) - 1;
    ua = int'(av) & mask;
    ub = int'(bv) & mask;
    r  = ua - ub - int'(bi);
    bo = (r < 0);
    d  = 16'(r & mask);
    sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    sr = sa - sb - int'(bi);
    ov = (sr < -(1 << (w - 1))) || (sr > (1 << (w - 1)) - 1);
    z  = (d == 16'd0);
  endtask

  // pulse start for one cycle; returns just after the accepting edge
  task automatic start_op(input int w, input logic [15:0] av, input logic [15:0] bv, input logic bi);
    @(negedge clk);
    if (w == 8) begin s8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; bin8 = bi; end
    else        begin s13 = 1'b1; a13 = av[12:0]; b13 = bv[12:0]; bin13 = bi; end
    @(negedge clk);
    s8 = 1'b0;
    s13 = 1'b0;
  endtask

  task automatic wait_done(input int w, input int k0, output int k);
    k = k0;
    do begin
      @(negedge clk);
      k++;
    end while (!cur_done(w) && k < 60);
  endtask

  task automatic run_exp(input string tag, input int w, input logic [15:0] av, input logic [15:0] bv,
                         input logic bi, input logic [15:0] ed, input logic ebo, input logic eov,
                         input logic ez);
    int k;
    start_op(w, av, bv, bi);
    wait_done(w, 0, k);
    check({tag, ".latency"}, 32'(k), 32'(w + 1));
    if (w == 8) begin
      check({tag, ".diff"}, 32'(diff8), 32'(ed));
      check({tag, ".bout"}, 32'(bout8), 32'(ebo));
      check({tag, ".ovf"},  32'(ovf8),  32'(eov));
      check({tag, ".zero"}, 32'(zero8), 32'(ez));
    end else begin
      check({tag, ".diff"}, 32'(diff13), 32'(ed));
      check({tag, ".bout"}, 32'(bout13), 32'(ebo));
      check({tag, ".ovf"},  32'(ovf13),  32'(eov));
      check({tag, ".zero"}, 32'(zero13), 32'(ez));
    end
  endtask

  task automatic run_random(input int w, input int n);
    logic [15:0] av, bv, ed;
    logic        bi, ebo, eov, ez;
    for (int i = 0; i < n; i++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      bi = 1'($urandom);
      // bias some operands toward corners
      if (i % 16 == 0) bv = av;
      if (i % 16 == 1) av = 16'hFFFF;
      model(w, av, bv, bi, ed, ebo, eov, ez);
      run_exp((w == 8) ? "rand8" : "rand13", w, av, bv, bi, ed, ebo, eov, ez);
    end
  endtask

  initial begin
    int k, j, seen;
    rst = 1'b1;
    s8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    s13 = 1'b0; a13 = '0; b13 = '0; bin13 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.busy", 32'(busy8), 32'd0);
    check("reset.done", 32'(done8), 32'd0);
    check("reset.diff", 32'(diff8), 32'd0);
    check("reset.flags", 32'({bout8, ovf8, zero8}), 32'd0);
    rst = 1'b0;

    // first op with cycle-by-cycle handshake checks
    start_op(8, 16'h05, 16'h03, 1'b0);
    check("t1.busy_e0", 32'(busy8), 32'd1);
    repeat (7) @(negedge clk);
    check("t1.busy_e7", 32'(busy8), 32'd1);
    check("t1.done_e7", 32'(done8), 32'd0);
    @(negedge clk);
    check("t1.busy_e8", 32'(busy8), 32'd0);
    check("t1.done_e8", 32'(done8), 32'd0);
    @(negedge clk);
    check("t1.done_e9", 32'(done8), 32'd1);
    check("t1.diff", 32'(diff8), 32'h02);
    check("t1.flags", 32'({bout8, ovf8, zero8}), 32'b000);
    @(negedge clk);
    check("t1.done_e10", 32'(done8), 32'd0);
    check("t1.diff_hold", 32'(diff8), 32'h02);

    run_exp("t2", 8, 16'h03, 16'h05, 1'b0, 16'hFE, 1'b1, 1'b0, 1'b0);
    run_exp("t3", 8, 16'h80, 16'h01, 1'b0, 16'h7F, 1'b0, 1'b1, 1'b0);
    run_exp("t4", 8, 16'h7F, 16'hFF, 1'b0, 16'h80, 1'b1, 1'b1, 1'b0);
    run_exp("t5", 8, 16'h10, 16'h0F, 1'b1, 16'h00, 1'b0, 1'b0, 1'b1);
    run_exp("t6", 8, 16'h00, 16'h00, 1'b1, 16'hFF, 1'b1, 1'b0, 1'b0);

    // start during SHIFT is ignored; start held through DONE chains the next op
    start_op(8, 16'h05, 16'h03, 1'b0);
    repeat (3) @(negedge clk);
    s8 = 1'b1; a8 = 8'h20; b8 = 8'h01;
    @(negedge clk);
    s8 = 1'b0;
    a8 = 8'h40; b8 = 8'h10; bin8 = 1'b0; s8 = 1'b1;
    wait_done(8, 4, k);
    s8 = 1'b0;
    check("b2b.latency1", 32'(k), 32'd9);
    check("b2b.diff1", 32'(diff8), 32'h02);
    check("b2b.busy2", 32'(busy8), 32'd1);
    wait_done(8, 0, j);
    check("b2b.gap", 32'(j), 32'd9);
    check("b2b.diff2", 32'(diff8), 32'h30);
    check("b2b.flags2", 32'({bout8, ovf8, zero8}), 32'b000);

    // reset in mid-operation discards the result
    start_op(8, 16'h44, 16'h11, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst.busy", 32'(busy8), 32'd0);
    check("rst.done", 32'(done8), 32'd0);
    check("rst.diff", 32'(diff8), 32'd0);
    check("rst.flags", 32'({bout8, ovf8, zero8}), 32'd0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8) seen++;
    end
    check("rst.no_done", 32'(seen), 32'd0);
    run_exp("rst.fresh", 8, 16'h44, 16'h11, 1'b0, 16'h33, 1'b0, 1'b0, 1'b0);

    // WIDTH=13 corners
    run_exp("w13.a", 13, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b1, 1'b0);
    run_exp("w13.b", 13, 16'h0000, 16'h0000, 1'b1, 16'h1FFF, 1'b1, 1'b0, 1'b0);

    run_random(8, 1000);
    run_random(13, 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Parametrised, bit-serial N-bit subtractor computing diff = a - b - bin, LSB first, one bit per clock.
- Each step uses one full-subtractor stage and a registered borrow.
- Successor to the combinational half/full subtractor cells: adds width generalisation, borrow-in, signed overflow and zero flags, and a start/busy/done handshake.
- Used as an area-cheap arithmetic unit where latency is not critical.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.
- CW, $clog2(WIDTH+1), bit-counter width; derived, not to be overridden.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request a new operation; sampled only when accepting.
- a, input, WIDTH, minuend; sampled on accepted start.
- b, input, WIDTH, subtrahend; sampled on accepted start.
- bin, input, 1, borrow-in; sampled on accepted start.
- busy, output, 1, high while an operation is in progress.
- done, output, 1, one-cycle pulse when results become valid.
- diff, output, WIDTH, difference; registered, held until next completion.
- bout, output, 1, borrow-out from MSB stage (unsigned a < b+bin).
- ovf, output, 1, signed two's-complement overflow.
- zero, output, 1, high when diff == 0.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset:
  - state = IDLE; busy = 0, done = 0, diff = 0, bout = 0, ovf = 0, zero = 0.
  - Internal shift registers, counter and borrow register cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start = 1 → load a, b into shift registers, borrow_r <= bin, cnt <= 0; go to SHIFT.
  - start = 0 → stay in IDLE.
- SHIFT (busy = 1):
  - Each cycle: d = a_sr[0] ^ b_sr[0] ^ borrow_r.
  - borrow_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow_r).
  - d shifts into the MSB of the result shift register; a_sr and b_sr shift right; borrow_r <= borrow_next; cnt++.
  - On the cycle cnt == WIDTH-1, capture borrow_r (borrow into the MSB stage) as b_msb_in.
  - After WIDTH shift cycles go to DONE.
- DONE (one cycle):
  - done = 1, busy = 0.
  - diff <= result register; bout <= borrow_r; ovf <= b_msb_in ^ borrow_r; zero <= (result == 0).
  - Outputs update on the same edge that raises done.
  - start = 1 here is accepted exactly as in IDLE (back-to-back ops); otherwise go to IDLE.
- Latency: start accepted at edge 0 → done high after edge WIDTH+1, so 9 cycles for WIDTH = 8. Throughput is one operation per WIDTH+1 cycles.
- start while in SHIFT is ignored. a, b and bin may change freely after acceptance.
- diff, bout, ovf and zero hold their values through IDLE and the next operation until the following DONE.
- rst asserted mid-operation: the next edge forces reset values, including done = 0. The in-flight result is discarded and no done pulse is produced.
- Arithmetic is modulo 2^WIDTH.

Decomposition:
- Shared package holds the state enum (IDLE, SHIFT, DONE) and a function computing the counter width from WIDTH.
- One sub-module, full_subtractor: combinational 1-bit cell with inputs x, y, bi and outputs d, bo, built from two half-subtractor stages plus an OR.
- serial_subtractor instantiates one full_subtractor.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, start 1 cycle → done at cycle 9; diff=0x02, bout=0, ovf=0, zero=0; busy high for cycles 1–8.
- a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1, ovf=0, zero=0.
- a=0x80, b=0x01, bin=0 → diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF → diff=0x80, bout=1, ovf=1.
- a=0x10, b=0x0F, bin=1 → diff=0x00, zero=1, bout=0, ovf=0. Then a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1.
- Pulse start again at cycle 4 of an op with different operands → ignored, first result unchanged. Hold start high through DONE → second op starts immediately, its done exactly 9 cycles after the first done.
- Assert rst at cycle 5 of an op → next cycle busy=0, done=0, diff=0, flags=0; no done pulse follows. A fresh start then completes normally.
- Random 1000 ops, WIDTH=8 and WIDTH=13 → compare diff, bout, ovf and zero against a reference model of a - b - bin.
